// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM states
// and the index-width helper used to size the nibble counter.
package nibble_serial_adder_pkg;

  // Width of one adder slice pass.
  localparam int NIBBLE_W = 4;

  // Operation sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count nibbles; a single-nibble adder still gets a 1-bit index.
  function automatic int idx_width(input int nibbles);
    int w;
    if (nibbles <= 1) begin
      w = 1;
    end else begin
      w = $clog2(nibbles);
    end
    return w;
  endfunction

endpackage

// File: rtl/ksa4_slice.sv
// Combinational 4-bit Kogge-Stone adder slice. The carry-in is folded into
// the bit-0 generate term so the two-level prefix tree yields every carry.
// c_msb is the carry into bit 3, needed by the caller for signed overflow.
module ksa4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c_msb
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] gin;
  logic [3:0] g1;
  logic [3:2] p1;
  logic [3:0] g2;
  logic [4:0] carry;

  // Generate/propagate prefix tree (distance 1, then distance 2) and sum bits.
  always_comb begin
    gen  = a & b;
    prop = a ^ b;

    gin    = gen;
    gin[0] = gen[0] | (prop[0] & cin);

    g1[0] = gin[0];
    for (int i = 1; i < 4; i++) begin
      g1[i] = gin[i] | (prop[i] & gin[i-1]);
    end
    for (int i = 2; i < 4; i++) begin
      p1[i] = prop[i] & prop[i-1];
    end

    g2[1:0] = g1[1:0];
    for (int i = 2; i < 4; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
    end

    carry = {g2, cin};
    sum   = prop ^ carry[3:0];
    cout  = carry[4];
    c_msb = carry[3];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: operands are latched on accept and passed
// through a single 4-bit slice, least-significant nibble first, with the
// slice carry registered between passes. Results are held until taken.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idx_width(NIBBLES);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  state_t           state;
  state_t           next_state;
  logic             ready_raw;
  logic             accept;
  logic             last;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    bit_base;
  logic [WIDTH-1:0] a_hold;
  logic [WIDTH-1:0] b_hold;
  logic             carry;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic             slice_c_msb;

  // Reset forces in_ready low; out_ready -> in_ready is a deliberate combinational path.
  assign in_ready = rst_n & ready_raw;
  assign accept   = in_valid & in_ready;
  assign last     = (idx == IDX_LAST);
  assign bit_base = {idx, 2'b00};
  assign slice_a  = a_hold[bit_base +: NIBBLE_W];
  assign slice_b  = b_hold[bit_base +: NIBBLE_W];

  ksa4_slice u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_c_msb)
  );

  // Next-state and ready decode; DONE with out_ready behaves like IDLE for back-to-back accepts.
  always_comb begin
    next_state = state;
    ready_raw  = 1'b0;
    case (state)
      IDLE: begin
        ready_raw = 1'b1;
        if (in_valid) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          ready_raw = 1'b1;
          if (in_valid) begin
            next_state = RUN;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
        ready_raw  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand latch, nibble index, inter-nibble carry and result assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_hold    <= {WIDTH{1'b0}};
      b_hold    <= {WIDTH{1'b0}};
      carry     <= 1'b0;
      idx       <= IDX_ZERO;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (next_state == DONE);
      if (accept) begin
        a_hold <= a;
        b_hold <= b;
        carry  <= cin;
        idx    <= IDX_ZERO;
      end else if (state == RUN) begin
        sum[bit_base +: NIBBLE_W] <= slice_sum;
        carry                     <= slice_cout;
        if (last) begin
          cout <= slice_cout;
          ovf  <= slice_c_msb ^ slice_cout;
          idx  <= IDX_ZERO;
        end else begin
          idx  <= idx + IDX_ONE;
        end
      end else begin
        idx <= idx;
      end
    end
  end

endmodule
